// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter, at most STEP bits per clock; out_valid rises ceil(shamt/STEP) edges after accept.
// Valid/ready on both sides, one operation in flight; SHIFT_UNIT_ROTATE_EN makes in_mode=11 a rotate-left.
module shift_unit #(
  parameter int N    = 32,
  parameter int STEP = 4,
  parameter int SW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SW:0] STEP_W = STEP[SW:0];

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_work, w_work_nxt;
  logic [SW-1:0] r_rem, w_rem_nxt;
  logic          r_sign;
  logic [1:0]    r_mode;
  logic [N-1:0]  r_out;
  logic          w_accept;
  logic          w_load_out;
  logic [SW-1:0] w_d;
  logic [N-1:0]  w_sll, w_srl, w_sra, w_shifted;
`ifdef SHIFT_UNIT_ROTATE_EN
  logic [SW:0]   w_nd;
  logic [N-1:0]  w_rol;
`endif

  assign in_ready  = (r_state == IDLE) && !reset;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out;

  // Per-cycle distance: the remainder, capped at STEP.
  always_comb begin
    w_d = r_rem;
    if ({1'b0, r_rem} >= STEP_W) begin
      w_d = STEP_W[SW-1:0];
    end
  end

  assign w_sll = r_work << w_d;
  assign w_srl = r_work >> w_d;
  assign w_sra = w_srl | (r_sign ? ~({N{1'b1}} >> w_d) : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
  assign w_nd  = N[SW:0] - {1'b0, w_d};
  assign w_rol = w_sll | (r_work >> w_nd);
`endif

  always_comb begin
    w_shifted = w_sll;
    case (r_mode)
      2'b01:   w_shifted = w_srl;
      2'b10:   w_shifted = w_sra;
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11:   w_shifted = w_rol;
`endif
      default: w_shifted = w_sll;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_rem_nxt   = r_rem;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_work_nxt  = in_data;
          w_rem_nxt   = in_shamt;
          w_state_nxt = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_work_nxt = w_shifted;
        w_rem_nxt  = r_rem - w_d;
        if (w_rem_nxt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result register is loaded only on entry to DONE so it holds across the next operation.
  assign w_load_out = (w_state_nxt == DONE) && (r_state != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_sign  <= 1'b0;
      r_mode  <= 2'b00;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_rem   <= w_rem_nxt;
      if (w_accept) begin
        r_sign <= in_data[N-1];
        r_mode <= in_mode;
      end
      if (w_load_out) begin
        r_out <= w_work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit, N=32 STEP=4.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int tests_run = 0;
  int fails     = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  shift_unit #(.N(32), .STEP(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] m);
    case (m)
      2'b01: return d >> s;
      2'b10: return 32'($signed(d) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
`endif
      default: return d << s;
    endcase
  endfunction

  // Waits for in_ready, presents one operand for a single accept edge, records the expectation.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready got %b exp 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = $urandom; in_shamt = 5'($urandom); in_mode = 2'($urandom);
    sb.push_back(model(d, int'(s), m));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state got rdy=%b vld=%b dat=%h exp 0 0 0", in_ready, out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_sll_basic();
    int lat;
    logic [31:0] e;
    issue(32'h3, 5'd2, 2'b00);
    wait_out(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 1 || out_data !== e) begin
      fails++;
      $display("FAIL sll_basic got lat=%0d dat=%h exp lat=1 dat=%h", lat, out_data, e);
    end
    handshake();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== e) begin
      fails++;
      $display("FAIL sll_after_hs got vld=%b rdy=%b dat=%h exp 0 1 %h", out_valid, in_ready, out_data, e);
    end
  endtask

  task automatic test_sra_srl();
    int lat;
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      issue(32'h80000000, 5'd31, (k == 0) ? 2'b10 : 2'b01);
      wait_out(lat);
      e = sb.pop_front();
      tests_run++;
      if (lat !== 8 || out_data !== e || e !== ((k == 0) ? 32'hFFFFFFFF : 32'h1)) begin
        fails++;
        $display("FAIL sr31_mode%0d got lat=%0d dat=%h exp lat=8 dat=%h", k, lat, out_data, e);
      end
      handshake();
    end
  endtask

  task automatic test_zero_shamt();
    int lat;
    logic [31:0] e;
    issue(32'hDEADBEEF, 5'd0, 2'b00);
    wait_out(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 0 || out_data !== 32'hDEADBEEF || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_shamt got lat=%0d dat=%h rdy=%b exp lat=0 dat=%h rdy=0", lat, out_data, in_ready, e);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] e;
    issue(32'hF0000000, 5'd4, 2'b01);
    wait_out(lat);
    e = sb[0];
    tests_run++;
    if (lat !== 1 || out_data !== 32'h0F000000) begin
      fails++;
      $display("FAIL bp_result got lat=%0d dat=%h exp lat=1 dat=0f000000", lat, out_data);
    end
    // A second operand waits on in_valid throughout the stall.
    in_valid = 1'b1; in_data = 32'h5; in_shamt = 5'd1; in_mode = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got vld=%b dat=%h rdy=%b exp 1 %h 0", c, out_valid, out_data, in_ready, e);
      end
    end
    void'(sb.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    sb.push_back(model(32'h5, 1, 2'b00));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 1 || out_data !== e || e !== 32'hA) begin
      fails++;
      $display("FAIL b2b_second got lat=%0d dat=%h exp lat=1 dat=%h", lat, out_data, e);
    end
    handshake();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [31:0] e;
    issue(32'h1, 5'd20, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midop_reset got vld=%b dat=%h rdy=%b exp 0 0 0", out_valid, out_data, in_ready);
    end
    sb.delete();
    reset = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midop_release_ready got %b exp 1", in_ready);
    end
    issue(32'h1, 5'd20, 2'b00);
    wait_out(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 5 || out_data !== 32'h00100000) begin
      fails++;
      $display("FAIL midop_fresh got lat=%0d dat=%h exp lat=5 dat=%h", lat, out_data, e);
    end
    handshake();
  endtask

  task automatic test_mode11();
    int lat;
    logic [31:0] e;
    logic [31:0] want;
`ifdef SHIFT_UNIT_ROTATE_EN
    want = 32'h00000018;
`else
    want = 32'h00000010;
`endif
    issue(32'h80000001, 5'd4, 2'b11);
    wait_out(lat);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 1 || out_data !== want || out_data !== e) begin
      fails++;
      $display("FAIL mode11 got lat=%0d dat=%h exp lat=1 dat=%h", lat, out_data, want);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    int s;
    logic [31:0] d;
    logic [1:0]  m;
    logic [31:0] e;
    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      s = $urandom_range(0, 31);
      m = 2'($urandom_range(0, 3));
      issue(d, 5'(s), m);
      wait_out(lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      e = sb.pop_front();
      tests_run++;
      if (lat !== (s + 3) / 4 || out_data !== e) begin
        fails++;
        $display("FAIL rand%0d d=%h s=%0d m=%0d got lat=%0d dat=%h exp lat=%0d dat=%h",
                 i, d, s, m, lat, out_data, (s + 3) / 4, e);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_sll_basic();
    test_sra_srl();
    test_zero_shamt();
    test_back_to_back();
    test_reset_midop();
    test_mode11();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Parametrised, multi-cycle shifter for the MIPS datapath. Supports logical left, logical right and arithmetic right shifts by a variable amount.
- Shifts at most STEP bits per clock, so area stays small compared with a full barrel shifter.
- Successor to the fixed shift-left-by-2 immediate path. Also serves the SLL/SRL/SRA/SLLV/SRLV/SRAV datapath.
- Uses a valid/ready handshake on input and output.

Parameters:
- N, 32: data width in bits, N >= 2.
- STEP, 4: maximum shift distance per clock, power of 2, 1 <= STEP <= N.
- SW, $clog2(N): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  unit can accept an operand
- in_data  in  N  value to shift
- in_shamt  in  SW  shift amount, 0..N-1
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  N  shifted result

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset state: FSM in IDLE, out_valid=0, out_data=0, internal shift-amount counter=0. in_ready=0 while reset is high, 1 in the first cycle after reset is released.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !reset. Combinational from state.
- Accept happens on a clock edge where in_valid && in_ready:
  - latch in_data into the working register, in_shamt into rem, and in_mode into the mode register;
  - latch sign = in_data[N-1];
  - go to SHIFT if in_shamt != 0, else go to DONE.
- SHIFT, on each edge:
  - d = min(rem, STEP);
  - shift the working register by d (SLL: zero fill; SRL: zero fill; SRA: fill with the latched sign);
  - rem <= rem - d;
  - if rem - d == 0, go to DONE.
- DONE:
  - out_valid=1; out_data = working register, held stable while out_ready=0;
  - on the edge with out_valid && out_ready, go to IDLE and drop out_valid. out_data keeps its last value.
- Latency: out_valid rises ceil(shamt/STEP) edges after the accept edge. For shamt=0 it is high in the cycle immediately after the accept edge.
- Throughput: one operation per (ceil(shamt/STEP) + 2) cycles minimum. No overlap; in_ready is 0 in SHIFT and DONE.
- in_data, in_shamt and in_mode are ignored when not accepting. Changing them mid-operation has no effect.
- in_valid held low: the FSM stays in IDLE and outputs are unchanged.
- Reset asserted in any state: at the next edge the block returns to the reset state, and the in-flight result is discarded.
- Shifts never exceed N-1 in total. rem never underflows.

Optional Feature:
- Macro SHIFT_UNIT_ROTATE_EN.
- Defined: in_mode=11 performs rotate-left. Bits shifted out of the MSB re-enter at the LSB, STEP bits per cycle max, with the same latency rule.
- Undefined: in_mode=11 is decoded as SLL, and no rotate logic is synthesised.

Test Plan:
All scenarios use N=32, STEP=4.
- SLL 0x00000003, shamt=2 -> out_data 0x0000000C; out_valid 1 edge after accept.
- SRA 0x80000000, shamt=31 -> 0xFFFFFFFF; out_valid exactly 8 edges after accept. SRL with the same inputs -> 0x00000001, also at 8 edges.
- shamt=0, SLL 0xDEADBEEF -> 0xDEADBEEF; out_valid in the cycle right after accept; in_ready=0 during DONE.
- Backpressure: SRL 0xF0000000, shamt=4 -> 0x0F000000. Hold out_ready=0 for 5 cycles: out_valid and out_data stay stable and in_ready stays 0. Raise out_ready: handshake, then in_ready=1 on the next cycle. Back-to-back in_valid is accepted only then.
- Reset mid-op: start SLL 0x1, shamt=20, assert reset after 2 SHIFT edges. The next cycle shows out_valid=0 and out_data=0. After reset is released, in_ready=1 and a fresh SLL 0x1, shamt=20 gives 0x00100000.
- Mode 11, data 0x80000001, shamt=4:
  - with SHIFT_UNIT_ROTATE_EN -> 0x00000018;
  - without it -> 0x00000010.
